regfile_writeback: RTL

- Write-side master of `registerMemory`'s write port (`we_RF`/`A3`/`WD3`). Only block allowed to drive that port.
- After reset it runs an init sequence over all 32 registers.
- It then accepts write-back requests from the execute/memory pipeline through a valid/ready handshake and buffers them in a small FIFO. It drains one write per cycle.
- It exposes a pending-write lookup so the decode/read side can forward data not yet committed to the bank.

---
 rtl/regfile_wb_pkg.sv | 18 +
 rtl/regfile_writeback_fifo.sv | 78 +++++++
 rtl/regfile_writeback.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/regfile_wb_pkg.sv
// Shared types for the register-file write-back path: buffered entry layout
// and the init/run state encoding.
package regfile_wb_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 5;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } wb_state_t;

endpackage

// File: rtl/regfile_writeback_fifo.sv
// Circular write-back buffer. Besides the head it presents every slot in age
// order (index 0 = oldest) with a valid bit, for the forwarding search.
module wb_fifo
  import regfile_wb_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = wb_entry_t
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  entry_t                     push_data_i,
  input  logic                       pop_i,
  output entry_t                     head_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o,
  output entry_t                     entries_o [DEPTH],
  output logic [DEPTH-1:0]           valid_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_push, do_pop;

  // Full/empty come from the occupancy counter so pointer equality is never ambiguous.
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries_o[i] = mem_q[rd_ptr_q + PTR_W'(i)];
      valid_o[i]   = (CNT_W'(i) < count_q);
    end
  end

endmodule

// File: rtl/regfile_writeback.sv
// Sole driver of the register bank write port: clears/seeds every register
// after reset, then drains buffered write-backs one per cycle with forwarding.
module regfile_writeback
  import regfile_wb_pkg::*;
#(
  parameter int DATA_W     = WB_DATA_W,
  parameter int ADDR_W     = WB_ADDR_W,
  parameter int NREGS      = 32,
  parameter int DEPTH      = 4,
  parameter int INIT_MODE  = 0,
  parameter int DISCARD_R0 = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_valid,
  output logic                     wb_ready,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  output logic                     we_RF,
  output logic [ADDR_W-1:0]        A3,
  output logic [DATA_W-1:0]        WD3,
  output logic                     init_done,
  input  logic [ADDR_W-1:0]        chk_addr,
  output logic                     chk_hit,
  output logic [DATA_W-1:0]        chk_data,
  output logic [$clog2(DEPTH):0]   pending
);

  localparam int ICNT_W = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  wb_state_t          state_q, state_d;
  logic [ICNT_W-1:0]  init_cnt_q, init_cnt_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  a3_q, a3_d;
  logic [DATA_W-1:0]  wd3_q, wd3_d;

  entry_t             push_entry;
  entry_t             head;
  entry_t             entries [DEPTH];
  logic [DEPTH-1:0]   entry_valid;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_full, fifo_empty;
  logic               push, pop;
  logic               drop_r0;

  assign init_done = (state_q == RUN);
  assign wb_ready  = (state_q == RUN) && !fifo_full;
  assign pending   = fifo_count;

  // Register-0 writes still complete the handshake but never enter the buffer.
  assign drop_r0    = (DISCARD_R0 != 0) && (wb_addr == '0);
  assign push       = wb_valid && wb_ready && !drop_r0;
  assign pop        = (state_q == RUN);
  assign push_entry = '{addr: wb_addr, data: wb_data};

  wb_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk_i       (clk),
    .rst_ni      (rst),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .entries_o   (entries),
    .valid_o     (entry_valid)
  );

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    we_d       = 1'b0;
    a3_d       = a3_q;
    wd3_d      = wd3_q;
    case (state_q)
      INIT: begin
        we_d  = 1'b1;
        a3_d  = ADDR_W'(init_cnt_q);
        wd3_d = (INIT_MODE != 0) ? DATA_W'(init_cnt_q) : '0;
        if (init_cnt_q == ICNT_W'(NREGS - 1)) begin
          state_d = RUN;
        end else begin
          init_cnt_d = init_cnt_q + ICNT_W'(1);
        end
      end
      RUN: begin
        if (!fifo_empty) begin
          we_d  = 1'b1;
          a3_d  = head.addr;
          wd3_d = head.data;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
      we_q       <= 1'b0;
      a3_q       <= '0;
      wd3_q      <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      we_q       <= we_d;
      a3_q       <= a3_d;
      wd3_q      <= wd3_d;
    end
  end

  assign we_RF = we_q;
  assign A3    = a3_q;
  assign WD3   = wd3_q;

  // Search oldest to youngest (output register, then buffer head..tail) so the last match wins.
  always_comb begin
    chk_hit  = 1'b0;
    chk_data = '0;
    if (state_q == RUN) begin
      if (we_q && (a3_q == chk_addr)) begin
        chk_hit  = 1'b1;
        chk_data = wd3_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (entry_valid[i] && (entries[i].addr == chk_addr)) begin
          chk_hit  = 1'b1;
          chk_data = entries[i].data;
        end
      end
    end
    if ((DISCARD_R0 != 0) && (chk_addr == '0)) begin
      chk_hit  = 1'b0;
      chk_data = '0;
    end
  end

endmodule
